vga_ball_mover: RTL

- Frame-synchronous controller that drives the ball peripheral's register write port. It is the single master on that port.
- Once per frame, on the vertical-sync assertion edge, it advances the ball position by a signed velocity and bounces it off the screen limits.
- It then issues register writes for the new x and y positions.
- Software sets the velocity and run/stop through a small config port.

---
 rtl/vga_ball_mover_pkg.sv | 27 ++
 rtl/vga_ball_mover_if.sv | 11 +
 rtl/vga_ball_mover_axis_step.sv | 42 ++++
 rtl/vga_ball_mover.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_ball_mover_pkg.sv
// Shared constants and state encoding for the VGA ball mover.
// Holds the register map, the screen geometry and the FSM state type.
package vga_ball_pkg;

  localparam logic [2:0] ADDR_R = 3'd0;
  localparam logic [2:0] ADDR_G = 3'd1;
  localparam logic [2:0] ADDR_B = 3'd2;
  localparam logic [2:0] ADDR_X = 3'd3;
  localparam logic [2:0] ADDR_Y = 3'd4;

  localparam int H_ACTIVE  = 1280;
  localparam int V_ACTIVE  = 480;
  localparam int BALL_DIAM = 32;

  typedef enum logic [3:0] {
    ST_INIT_X,
    ST_INIT_Y,
    ST_IDLE,
    ST_CALC,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_R,
    ST_WR_G,
    ST_WR_B
  } mover_state_t;

endpackage

// File: rtl/vga_ball_mover_if.sv
// Write port of the ball peripheral register file (no wait states).
// The mover drives it as master; the ball peripheral is the slave.
interface vga_ball_mover_if;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;

  modport master (output chipselect, write, address, writedata);
  modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/vga_ball_mover_axis_step.sv
// One axis of ball motion: next position and velocity with bounce at 0 and MAX.
// The sum is formed one bit wider than the position so that underflow shows as negative.
module vga_axis_step #(
  parameter int unsigned POS_W = 11,
  parameter int unsigned VEL_W = 5,
  parameter int unsigned MAX   = 1248
) (
  input  logic        [POS_W-1:0] i_pos,
  input  logic signed [VEL_W-1:0] i_vel,
  output logic        [POS_W-1:0] o_pos,
  output logic signed [VEL_W-1:0] o_vel,
  output logic                    o_bounced
);

  localparam logic signed [POS_W:0] LIM = (POS_W+1)'(MAX);

  logic signed [POS_W:0]   w_sum;
  logic signed [VEL_W-1:0] w_vel_neg;

  assign w_sum = $signed({1'b0, i_pos}) +
                 $signed({{(POS_W+1-VEL_W){i_vel[VEL_W-1]}}, i_vel});

  // -(most negative) does not fit; clamp to the most positive velocity
  assign w_vel_neg = (i_vel == {1'b1, {(VEL_W-1){1'b0}}}) ?
                     {1'b0, {(VEL_W-1){1'b1}}} : -i_vel;

  always_comb begin
    o_pos     = w_sum[POS_W-1:0];
    o_vel     = i_vel;
    o_bounced = 1'b0;
    if (w_sum < 0) begin
      o_pos     = '0;
      o_vel     = w_vel_neg;
      o_bounced = 1'b1;
    end else if (w_sum > LIM) begin
      o_pos     = LIM[POS_W-1:0];
      o_vel     = w_vel_neg;
      o_bounced = 1'b1;
    end
  end

endmodule

// File: rtl/vga_ball_mover.sv
// Frame-synchronous ball mover: steps x/y once per VS falling edge and writes them out.
// Optional VGA_BALL_MOVER_BOUNCE_COLOR_EN adds a hue that changes on every bounce.
module vga_ball_mover
  import vga_ball_pkg::*;
#(
  parameter int unsigned X_MAX   = H_ACTIVE - BALL_DIAM,
  parameter int unsigned Y_MAX   = V_ACTIVE - BALL_DIAM,
  parameter int unsigned X_INIT  = 624,
  parameter int unsigned Y_INIT  = 224,
  parameter int unsigned VEL_W   = 5,
  parameter int          DX_INIT = 2,
  parameter int          DY_INIT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    vga_vs,
  input  logic                    cfg_valid,
  input  logic                    cfg_run,
  input  logic signed [VEL_W-1:0] cfg_dx,
  input  logic signed [VEL_W-1:0] cfg_dy,
  vga_ball_mover_if.master        bus,
  output logic                    busy,
  output logic [10:0]             x_cur,
  output logic [9:0]              y_cur
);

  mover_state_t r_state, w_state_nxt;

  logic                    r_vs_q;
  logic [10:0]             r_x;
  logic [9:0]              r_y;
  logic signed [VEL_W-1:0] r_dx, r_dy;
  logic                    r_run;

  logic        r_cs, w_cs_nxt;
  logic [2:0]  r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;

  logic                    w_tick, w_cfg_ok, w_run_eff;
  logic [10:0]             w_x_nxt;
  logic [9:0]              w_y_nxt;
  logic signed [VEL_W-1:0] w_dx_nxt, w_dy_nxt;
  logic                    w_x_bounce, w_y_bounce;

`ifdef VGA_BALL_MOVER_BOUNCE_COLOR_EN
  logic [7:0] r_hue;
  logic       r_bounced;
`endif

  vga_axis_step #(.POS_W(11), .VEL_W(VEL_W), .MAX(X_MAX)) u_x_step (
    .i_pos(r_x), .i_vel(r_dx), .o_pos(w_x_nxt), .o_vel(w_dx_nxt), .o_bounced(w_x_bounce)
  );

  vga_axis_step #(.POS_W(10), .VEL_W(VEL_W), .MAX(Y_MAX)) u_y_step (
    .i_pos(r_y), .i_vel(r_dy), .o_pos(w_y_nxt), .o_vel(w_dy_nxt), .o_bounced(w_y_bounce)
  );

  assign w_tick    = r_vs_q & ~vga_vs;
  assign w_cfg_ok  = cfg_valid & (r_state inside {ST_IDLE, ST_INIT_X, ST_INIT_Y});
  assign w_run_eff = w_cfg_ok ? cfg_run : r_run;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_INIT_X;
      r_vs_q  <= 1'b1;
      r_x     <= 11'(X_INIT);
      r_y     <= 10'(Y_INIT);
      r_dx    <= VEL_W'(DX_INIT);
      r_dy    <= VEL_W'(DY_INIT);
      r_run   <= 1'b1;
      r_cs    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef VGA_BALL_MOVER_BOUNCE_COLOR_EN
      r_hue     <= '0;
      r_bounced <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_vs_q  <= vga_vs;
      r_cs    <= w_cs_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_cfg_ok) begin
        r_dx  <= cfg_dx;
        r_dy  <= cfg_dy;
        r_run <= cfg_run;
      end
      if (r_state == ST_CALC) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_dx <= w_dx_nxt;
        r_dy <= w_dy_nxt;
`ifdef VGA_BALL_MOVER_BOUNCE_COLOR_EN
        r_bounced <= w_x_bounce | w_y_bounce;
        if (w_x_bounce | w_y_bounce) r_hue <= r_hue + 8'd37;
`endif
      end
    end
  end

  // Bus outputs are registered: each state loads the write that appears on the
  // bus during the following cycle, so reset can hold chipselect low.
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    case (r_state)
      ST_INIT_X: begin
        w_state_nxt = ST_INIT_Y;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_X;
        w_wdata_nxt = 32'(X_INIT);
      end
      ST_INIT_Y: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_Y;
        w_wdata_nxt = 32'(Y_INIT);
      end
      ST_IDLE: begin
        if (w_tick && w_run_eff) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        w_state_nxt = ST_WR_X;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_X;
        w_wdata_nxt = 32'(w_x_nxt);
      end
      ST_WR_X: begin
        w_state_nxt = ST_WR_Y;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_Y;
        w_wdata_nxt = 32'(r_y);
      end
`ifdef VGA_BALL_MOVER_BOUNCE_COLOR_EN
      ST_WR_Y: begin
        if (r_bounced) begin
          w_state_nxt = ST_WR_R;
          w_cs_nxt    = 1'b1;
          w_addr_nxt  = ADDR_R;
          w_wdata_nxt = 32'(r_hue);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_R: begin
        w_state_nxt = ST_WR_G;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_G;
        w_wdata_nxt = 32'(r_hue ^ 8'hFF);
      end
      ST_WR_G: begin
        w_state_nxt = ST_WR_B;
        w_cs_nxt    = 1'b1;
        w_addr_nxt  = ADDR_B;
        w_wdata_nxt = 32'(8'h80);
      end
      ST_WR_B: w_state_nxt = ST_IDLE;
`else
      ST_WR_Y: w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.chipselect = r_cs;
  assign bus.write      = r_cs;
  assign bus.address    = r_addr;
  assign bus.writedata  = r_wdata;

  assign busy  = (r_state != ST_IDLE);
  assign x_cur = r_x;
  assign y_cur = r_y;

endmodule
